pciecfg_engine: RTL
===================

Name: pciecfg_engine

Overview:
- Parametrised successor of the PCIe configuration-space access core.
- Pops request words from a FWFT request FIFO and drives the 7-series cfg_mgmt port.
- Supports read, write and masked read-modify-write, with a per-access timeout and status reporting.
- Pushes tagged response words, each followed by a configurable number of all-zero pad beats, into a response FIFO feeding the UDP packetiser.

Parameters:
- DWADDR_W, 10, cfg_mgmt DW address width.
- DATA_W, 32, config data width; BE_W = DATA_W/8.
- TAG_W, 8, request tag width, echoed in the response.
- TIMEOUT_CYC, 1024, max cycles a strobe is held awaiting done; minimum 2.
- PAD_BEATS, 5, zero beats after each response; 0 disables padding.
- WR_ACK, 1, 1 = writes and RMWs produce a response; 0 = only reads and errors respond.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous reset, active low.
- req_rd_en  out  1  pop strobe to the request FIFO.
- req_empty  in  1  request FIFO empty.
- req_dout  in  2+TAG_W+BE_W+DWADDR_W+DATA_W  FWFT word {opc[1:0], tag, byte_en, dwaddr, data}, MSB first.
- rsp_wr_en  out  1  push strobe to the response FIFO.
- rsp_full  in  1  response FIFO full.
- rsp_din  out  2+TAG_W+DWADDR_W+DATA_W  {status[1:0], tag, dwaddr, data}.
- cfg_mgmt_dwaddr  out  DWADDR_W  access address.
- cfg_mgmt_rd_en  out  1  read strobe.
- cfg_mgmt_wr_en  out  1  write strobe.
- cfg_mgmt_byte_en  out  BE_W  write byte enables.
- cfg_mgmt_di  out  DATA_W  write data.
- cfg_mgmt_do  in  DATA_W  read data, valid with done.
- cfg_mgmt_rd_wr_done  in  1  access complete.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Opcodes: 00 RD, 01 WR, 10 RMW, 11 illegal.
- Status codes: 00 OK, 01 TIMEOUT, 10 BAD_OPC.
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, latched request, counters and response data cleared.
- Reset mid-access: strobes drop on that same edge; the pending request is lost and no response is written.
- All outputs are registered.

State machine:
- IDLE: if !req_empty, pulse req_rd_en for exactly 1 cycle, latch req_dout, then go to:
  - RD_ISSUE for RD or RMW;
  - WR_ISSUE for WR;
  - RSP with status BAD_OPC for opcode 11.
- WR with byte_en==0 goes to RSP (OK) without any strobe, subject to WR_ACK.
- RD_ISSUE: rd_en=1 and dwaddr held constant until done.
  - On done: rd_en=0 next edge; rsp data = cfg_mgmt_do.
  - RD goes to RSP.
  - RMW goes to MERGE; merge data = (do & ~mask) | (req.data & mask), with mask byte-expanded from byte_en.
- MERGE: 1 cycle; load cfg_mgmt_di with the merged word and byte_en with all ones, then go to WR_ISSUE.
- WR_ISSUE: wr_en=1; di, byte_en and dwaddr held stable until done.
  - On done: wr_en=0; rsp data = written word.
  - Go to RSP if WR_ACK, else PAD_SKIP (returns to IDLE).
- Timeout:
  - Counter clears on entry to each ISSUE state and increments every cycle a strobe is high.
  - If done is absent on the TIMEOUT_CYC-th cycle of the strobe, the strobe drops, status=TIMEOUT, rsp data=0, and the state goes to RSP. RMW aborts without writing.
  - Done arriving on that same cycle wins: status OK.
  - Timeout responses are always sent regardless of WR_ACK.
- RSP: hold until !rsp_full, then 1-cycle rsp_wr_en with rsp_din valid. Go to PAD, or to IDLE if PAD_BEATS==0.
- PAD: each cycle with !rsp_full, push an all-zero word. After PAD_BEATS pushes, go to IDLE. While full, stall with no push.
- Throughput: at most one request in flight. The next pop happens no earlier than the cycle after returning to IDLE.
- Ignored inputs: cfg_mgmt_rd_wr_done outside the ISSUE states. rsp_full is sampled only in RSP and PAD.

Test Plan:
- RD tag=0x11, dwaddr=0x004; done after 3 cycles with do=0x00100007 -> rd_en high for exactly 3 cycles; response {00,0x11,0x004,0x00100007}; then 5 zero beats; req_rd_en pulsed once.
- WR byte_en=0xC, data=0xABCD0000, WR_ACK=1 -> wr_en held until done, di=0xABCD0000, byte_en=0xC; response status 00; with WR_ACK=0, no rsp_wr_en at all.
- RMW byte_en=0x1, data=0x000000FF; read returns 0x12345678 -> di=0x123456FF, byte_en=0xF; response data 0x123456FF.
- TIMEOUT_CYC=8, done never asserted -> strobe high for exactly 8 cycles; response {01,tag,addr,0}. Repeat with done on cycle 8 -> status 00.
- rsp_full high for 10 cycles during RSP, then toggling during PAD -> no push while full; exactly 1+PAD_BEATS pushes; no new pop until IDLE.
- Opcode 11 -> no strobes, status 10. rst_n low mid-RD_ISSUE -> rd_en 0 on the next edge; busy 0; no response written.

Source files
------------

// File: rtl/pciecfg_engine.sv
// Config-space access engine: pops requests from a FWFT FIFO, drives the 7-series
// cfg_mgmt port (read / write / masked RMW with timeout), and pushes tagged, padded responses.
module pciecfg_engine #(
  parameter int DWADDR_W    = 10,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int PAD_BEATS   = 5,
  parameter int WR_ACK      = 1,
  localparam int BE_W  = DATA_W/8,
  localparam int REQ_W = 2+TAG_W+BE_W+DWADDR_W+DATA_W,
  localparam int RSP_W = 2+TAG_W+DWADDR_W+DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                req_rd_en,
  input  logic                req_empty,
  input  logic [REQ_W-1:0]    req_dout,
  output logic                rsp_wr_en,
  input  logic                rsp_full,
  output logic [RSP_W-1:0]    rsp_din,
  output logic [DWADDR_W-1:0] cfg_mgmt_dwaddr,
  output logic                cfg_mgmt_rd_en,
  output logic                cfg_mgmt_wr_en,
  output logic [BE_W-1:0]     cfg_mgmt_byte_en,
  output logic [DATA_W-1:0]   cfg_mgmt_di,
  input  logic [DATA_W-1:0]   cfg_mgmt_do,
  input  logic                cfg_mgmt_rd_wr_done,
  output logic                busy
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int PW = (PAD_BEATS > 1) ? $clog2(PAD_BEATS) : 1;
  localparam logic [1:0] OPC_RD = 2'b00, OPC_WR = 2'b01, OPC_RMW = 2'b10;
  localparam logic [1:0] ST_OK = 2'b00, ST_TO = 2'b01, ST_BAD = 2'b10;

  typedef struct packed {
    logic [1:0]          opc;
    logic [TAG_W-1:0]    tag;
    logic [BE_W-1:0]     be;
    logic [DWADDR_W-1:0] addr;
    logic [DATA_W-1:0]   data;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_MERGE, S_WR_ISSUE, S_RSP, S_PAD, S_PAD_SKIP
  } state_e;

  state_e              state_q, state_d;
  req_t                req_q, req_d, req_in;
  logic [1:0]          st_q, st_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic                req_rd_en_q, req_rd_en_d, rsp_wr_en_q, rsp_wr_en_d;
  logic [RSP_W-1:0]    rsp_din_q, rsp_din_d;
  logic [DWADDR_W-1:0] addr_q, addr_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d, busy_q, busy_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   di_q, di_d, mask, merged;

  assign req_in = req_t'(req_dout);

  for (genvar g = 0; g < BE_W; g++) begin : g_mask
    assign mask[g*8 +: 8] = {8{req_q.be[g]}};
  end
  // rdata_q holds the value read back during the RMW read phase
  assign merged = (rdata_q & ~mask) | (req_q.data & mask);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    st_d        = st_q;
    rdata_d     = rdata_q;
    tcnt_d      = tcnt_q;
    pcnt_d      = pcnt_q;
    req_rd_en_d = 1'b0;
    rsp_wr_en_d = 1'b0;
    rsp_din_d   = '0;
    addr_d      = addr_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    be_d        = be_q;
    di_d        = di_q;
    case (state_q)
      S_IDLE: if (!req_empty) begin
        req_rd_en_d = 1'b1;
        req_d       = req_in;
        addr_d      = req_in.addr;
        st_d        = ST_OK;
        rdata_d     = '0;
        tcnt_d      = '0;
        pcnt_d      = '0;
        case (req_in.opc)
          OPC_RD, OPC_RMW: begin
            rd_en_d = 1'b1;
            state_d = S_RD_ISSUE;
          end
          OPC_WR: if (req_in.be == '0) begin
            rdata_d = req_in.data;
            state_d = (WR_ACK != 0) ? S_RSP : S_PAD_SKIP;
          end else begin
            wr_en_d = 1'b1;
            di_d    = req_in.data;
            be_d    = req_in.be;
            state_d = S_WR_ISSUE;
          end
          default: begin
            st_d    = ST_BAD;
            state_d = S_RSP;
          end
        endcase
      end
      S_RD_ISSUE: begin
        tcnt_d = tcnt_q + 1'b1;
        if (cfg_mgmt_rd_wr_done) begin
          rd_en_d = 1'b0;
          rdata_d = cfg_mgmt_do;
          state_d = (req_q.opc == OPC_RMW) ? S_MERGE : S_RSP;
        end else if (tcnt_q == TW'(TIMEOUT_CYC-1)) begin
          rd_en_d = 1'b0;
          st_d    = ST_TO;
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      S_MERGE: begin
        di_d    = merged;
        be_d    = '1;
        wr_en_d = 1'b1;
        tcnt_d  = '0;
        state_d = S_WR_ISSUE;
      end
      S_WR_ISSUE: begin
        tcnt_d = tcnt_q + 1'b1;
        if (cfg_mgmt_rd_wr_done) begin
          wr_en_d = 1'b0;
          rdata_d = di_q;
          state_d = (WR_ACK != 0) ? S_RSP : S_PAD_SKIP;
        end else if (tcnt_q == TW'(TIMEOUT_CYC-1)) begin
          wr_en_d = 1'b0;
          st_d    = ST_TO;
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      S_RSP: if (!rsp_full) begin
        rsp_wr_en_d = 1'b1;
        rsp_din_d   = {st_q, req_q.tag, req_q.addr, rdata_q};
        pcnt_d      = '0;
        state_d     = (PAD_BEATS == 0) ? S_IDLE : S_PAD;
      end
      S_PAD: if (!rsp_full) begin
        rsp_wr_en_d = 1'b1;
        pcnt_d      = pcnt_q + 1'b1;
        if (pcnt_q == PW'(PAD_BEATS-1)) state_d = S_IDLE;
      end
      S_PAD_SKIP: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      st_q        <= '0;
      rdata_q     <= '0;
      tcnt_q      <= '0;
      pcnt_q      <= '0;
      req_rd_en_q <= 1'b0;
      rsp_wr_en_q <= 1'b0;
      rsp_din_q   <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      be_q        <= '0;
      di_q        <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      st_q        <= st_d;
      rdata_q     <= rdata_d;
      tcnt_q      <= tcnt_d;
      pcnt_q      <= pcnt_d;
      req_rd_en_q <= req_rd_en_d;
      rsp_wr_en_q <= rsp_wr_en_d;
      rsp_din_q   <= rsp_din_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      be_q        <= be_d;
      di_q        <= di_d;
      busy_q      <= busy_d;
    end
  end

  assign req_rd_en        = req_rd_en_q;
  assign rsp_wr_en        = rsp_wr_en_q;
  assign rsp_din          = rsp_din_q;
  assign cfg_mgmt_dwaddr  = addr_q;
  assign cfg_mgmt_rd_en   = rd_en_q;
  assign cfg_mgmt_wr_en   = wr_en_q;
  assign cfg_mgmt_byte_en = be_q;
  assign cfg_mgmt_di      = di_q;
  assign busy             = busy_q;
endmodule
